osc_phase_multi: RTL and testbench

Parametrised phase-accumulator oscillator, successor to the division-based saw/triangle generator. It produces sawtooth, triangle and variable-duty square outputs from one accumulator, with amplitude scaling, glitch-free frequency retuning at period boundaries, and a hard phase sync. It sits between the key/frequency decoder and the mixer. It advances only on a sample-rate enable, so one clock domain serves any sample rate.

---
 rtl/osc_phase_multi_if.sv | 29 ++
 rtl/osc_phase_multi.sv | 134 +++++++++++++
 tb/tb_osc_phase_multi.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/osc_phase_multi_if.sv
// Port bundle for osc_phase_multi: tuning and sample strobe in, scaled waveforms out.
// sample_en is a one-cycle strobe with no backpressure; out_valid is a one-cycle pulse with no ready.
interface osc_phase_multi_if #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
);
  logic             sample_en;
  logic [ACC_W-1:0] inc_in;
  logic             inc_load;
  logic             inc_pending;
  logic             sync;
  logic [OUT_W-1:0] duty;
  logic [OUT_W-1:0] amp;
  logic [OUT_W-1:0] saw;
  logic [OUT_W-1:0] tri_o;
  logic [OUT_W-1:0] sqr;
  logic             out_valid;
  logic             wrap;

  modport master (
    output sample_en, inc_in, inc_load, sync, duty, amp,
    input  inc_pending, saw, tri_o, sqr, out_valid, wrap
  );

  modport slave (
    input  sample_en, inc_in, inc_load, sync, duty, amp,
    output inc_pending, saw, tri_o, sqr, out_valid, wrap
  );
endinterface

// File: rtl/osc_phase_multi.sv
// Phase-accumulator oscillator: saw/triangle/square from one accumulator, shadowed
// increment applied at period boundaries, hard sync, amplitude scaling, 2-cycle latency.
module osc_phase_multi #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  osc_phase_multi_if.slave  bus
);
  localparam logic [OUT_W-1:0] POS_FULL = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FULL = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] inc_act_q, inc_act_d;
  logic [ACC_W-1:0] inc_shd_q, inc_shd_d;
  logic             pending_q, pending_d;

  logic [ACC_W:0]   sum;
  logic             upd_wrap;
  logic             apply;

  logic [OUT_W-1:0] p, p_fold, t;
  logic [OUT_W-1:0] saw_raw_d, tri_raw_d, sqr_raw_d;

  logic [OUT_W-1:0] saw_raw_q, tri_raw_q, sqr_raw_q, amp_q;
  logic             v1_q, wrap1_q;

  logic [OUT_W-1:0] saw_q, tri_q, sqr_q;
  logic             valid_q, wrap_q;

  assign sum      = {1'b0, phase_q} + {1'b0, inc_act_q};
  assign upd_wrap = bus.sync | sum[ACC_W];
  // A zero increment never wraps, so it is allowed to pick up the shadow on any sample.
  assign apply    = bus.sample_en & (upd_wrap | (inc_act_q == '0));

  always_comb begin
    phase_d   = phase_q;
    inc_act_d = inc_act_q;
    inc_shd_d = inc_shd_q;
    pending_d = pending_q;
    if (bus.sample_en) begin
      phase_d = bus.sync ? '0 : sum[ACC_W-1:0];
    end
    if (apply) begin
      inc_act_d = inc_shd_q;
      pending_d = 1'b0;
    end
    if (bus.inc_load) begin
      inc_shd_d = bus.inc_in;
      pending_d = 1'b1;
    end
  end

  // Raw waveforms are derived from the post-update phase so they register alongside it.
  always_comb begin
    p         = phase_d[ACC_W-1 -: OUT_W];
    p_fold    = p[OUT_W-1] ? ~p : p;
    t         = {p_fold[OUT_W-2:0], 1'b0};
    saw_raw_d = {~p[OUT_W-1], p[OUT_W-2:0]};
    tri_raw_d = {~t[OUT_W-1], t[OUT_W-2:0]};
    sqr_raw_d = (p < bus.duty) ? POS_FULL : NEG_FULL;
  end

  function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] raw,
                                               input logic [OUT_W-1:0] gain);
    logic signed [2*OUT_W:0] a;
    logic signed [2*OUT_W:0] b;
    logic signed [2*OUT_W:0] prod;
    a    = {{(OUT_W+1){raw[OUT_W-1]}}, raw};
    b    = {{(OUT_W+1){1'b0}}, gain};
    prod = a * b;
    return OUT_W'(prod >>> OUT_W);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      inc_act_q <= '0;
      inc_shd_q <= '0;
      pending_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      inc_act_q <= inc_act_d;
      inc_shd_q <= inc_shd_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saw_raw_q <= '0;
      tri_raw_q <= '0;
      sqr_raw_q <= '0;
      amp_q     <= '0;
      v1_q      <= 1'b0;
      wrap1_q   <= 1'b0;
    end else begin
      v1_q    <= bus.sample_en;
      wrap1_q <= bus.sample_en & upd_wrap;
      if (bus.sample_en) begin
        saw_raw_q <= saw_raw_d;
        tri_raw_q <= tri_raw_d;
        sqr_raw_q <= sqr_raw_d;
        amp_q     <= bus.amp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saw_q   <= '0;
      tri_q   <= '0;
      sqr_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      valid_q <= v1_q;
      wrap_q  <= wrap1_q;
      if (v1_q) begin
        saw_q <= scale(saw_raw_q, amp_q);
        tri_q <= scale(tri_raw_q, amp_q);
        sqr_q <= scale(sqr_raw_q, amp_q);
      end
    end
  end

  assign bus.inc_pending = pending_q;
  assign bus.saw         = saw_q;
  assign bus.tri_o       = tri_q;
  assign bus.sqr         = sqr_q;
  assign bus.out_valid   = valid_q;
  assign bus.wrap        = wrap_q;
endmodule

// File: tb/tb_osc_phase_multi.sv
// Bench for osc_phase_multi: arithmetic reference model feeds an expected queue,
// a negedge monitor pops and compares on every out_valid.
module tb_osc_phase_multi;
  localparam int     ACC_W = 24;
  localparam int     OUT_W = 16;
  localparam longint MOD   = 64'd1 << ACC_W;
  localparam int     EXP_W = 32 + 1 + 3*OUT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  osc_phase_multi_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  osc_phase_multi #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [EXP_W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  longint m_phase = 0, m_act = 0, m_shd = 0;
  bit     m_pend  = 1'b0;
  logic [OUT_W-1:0] g_amp = '0, g_duty = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint fdiv(input longint n);
    return (n >= 0) ? n / 65536 : -((-n + 65535) / 65536);
  endfunction

  function automatic logic [47:0] waves(input longint ph, input longint a, input longint d);
    longint p, s, t, q;
    p = ph / 256;
    s = p - 32768;
    t = (((p < 32768) ? p : 65535 - p) * 2) % 65536 - 32768;
    q = (p < d) ? 32767 : -32767;
    return {16'(fdiv(s * a)), 16'(fdiv(t * a)), 16'(fdiv(q * a))};
  endfunction

  task automatic step(input bit se, input bit sy, input bit ld, input longint inc);
    longint sum;
    bit     w;
    @(negedge clk);
    check("inc_pending", bus.inc_pending, m_pend);
    bus.sample_en = se;
    bus.sync      = sy;
    bus.inc_load  = ld;
    bus.inc_in    = 24'(inc);
    bus.amp       = g_amp;
    bus.duty      = g_duty;
    if (se) begin
      sum = m_phase + m_act;
      w   = sy || (sum >= MOD);
      m_phase = sy ? 0 : sum % MOD;
      if (w || m_act == 0) begin
        m_act  = m_shd;
        m_pend = 1'b0;
      end
      exp_q.push_back({32'(cyc), w, waves(m_phase, longint'(g_amp), longint'(g_duty))});
    end
    if (ld) begin
      m_shd  = inc;
      m_pend = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_saw"}, bus.saw, 0);
    check({tag, "_tri"}, bus.tri_o, 0);
    check({tag, "_sqr"}, bus.sqr, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_wrap"}, bus.wrap, 0);
    check({tag, "_pending"}, bus.inc_pending, 0);
  endtask

  // Monitor: every out_valid must match the oldest outstanding sample, two cycles after issue.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valid: out_valid=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("saw", $signed(bus.saw), $signed(e[47:32]));
        check("tri", $signed(bus.tri_o), $signed(e[31:16]));
        check("sqr", $signed(bus.sqr), $signed(e[15:0]));
        check("wrap", bus.wrap, e[48]);
        check("latency", cyc - int'(e[EXP_W-1 -: 32]), 2);
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) + 2 <= cyc) begin
      e = exp_q.pop_front();
      n_chk++;
      $display("FAIL missing_valid: out_valid=0 required 1 for sample issued cycle %0d (cycle %0d)",
               int'(e[EXP_W-1 -: 32]), cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_en = 1'b0;
    bus.sync      = 1'b0;
    bus.inc_load  = 1'b0;
    bus.inc_in    = '0;
    bus.amp       = '0;
    bus.duty      = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Basic waveforms: 16-sample period, first sample at phase 0.
    g_amp = 16'hFFFF; g_duty = 16'h8000;
    step(1'b0, 1'b0, 1'b1, 'h100000);
    repeat (40) begin step(1'b1, 1'b0, 1'b0, 0); idle(3); end

    // Gain: half scale then zero.
    g_amp = 16'h8000;
    repeat (16) begin step(1'b1, 1'b0, 1'b0, 0); idle(1); end
    g_amp = 16'h0000;
    repeat (4) begin step(1'b1, 1'b0, 1'b0, 0); idle(1); end

    // Glitch-free retune mid-period.
    g_amp = 16'hFFFF;
    repeat (5) begin step(1'b1, 1'b0, 1'b0, 0); idle(1); end
    step(1'b0, 1'b0, 1'b1, 'h200000);
    repeat (20) begin step(1'b1, 1'b0, 1'b0, 0); idle(1); end

    // Coincident load and apply at a wrapping sample.
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 'h040000);
    for (int i = 0; i < 40; i++) begin
      if (m_phase + m_act >= MOD) begin
        step(1'b1, 1'b0, 1'b1, 'h080000);
        break;
      end
      step(1'b1, 1'b0, 1'b0, 0);
    end
    repeat (40) step(1'b1, 1'b0, 1'b0, 0);

    // Sync at phase 0x5A0000, then sync without sample_en.
    step(1'b0, 1'b0, 1'b1, 'h120000);
    step(1'b1, 1'b1, 1'b0, 0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 0);
    check("sync_phase_model", m_phase, 'h5A0000);
    step(1'b1, 1'b1, 1'b0, 0);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 0);
    idle(2);
    repeat (4) begin step(1'b1, 1'b0, 1'b0, 0); idle(1); end

    // Randomised traffic.
    repeat (400) begin
      bit se, sy, ld;
      longint inc;
      se  = 1'($urandom_range(0, 1));
      sy  = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      inc = longint'($urandom_range(0, 'h3FFFFF));
      if ($urandom_range(0, 7) == 0) g_amp  = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) g_duty = 16'($urandom_range(0, 65535));
      step(se, sy, ld, inc);
    end

    // Full throughput.
    g_amp = 16'hFFFF; g_duty = 16'h4000;
    repeat (30) step(1'b1, 1'b0, 1'b0, 0);
    idle(3);

    // Reset with two samples in flight.
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    bus.sample_en = 1'b0;
    #1;
    check_zero("midreset");
    exp_q.delete();
    m_phase = 0; m_act = 0; m_shd = 0; m_pend = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    step(1'b0, 1'b0, 1'b1, 'h100000);
    idle(2);
    repeat (10) step(1'b1, 1'b0, 1'b0, 0);
    idle(5);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
